dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single-ported 3072-word data RAM between the M-stage load/store port and an external DMA/debug port.
- Generates byte enables and lane-aligned write data for stores.
- Selects, shifts and extends load data.
- Stalls the pipeline while a load is in flight or while the DMA owns the RAM.
- Sits between the M stage and the RAM array; the RAM has 1-cycle synchronous read and byte-enabled synchronous write.

Parameters:
- ADDR_W, 12, word-index width driven to the RAM (3072 words used).
- MAX_WAIT, 4, consecutive cycles the DMA may be denied before it is forced priority.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  M stage has a load or store this cycle
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_width  in  2  access width: WORD 2'b00, HALF 2'b01, BYTE 2'b10
- cpu_loadop  in  1  1 = sign-extend, 0 = zero-extend
- cpu_stall  out  1  hold the M stage and everything upstream
- cpu_rdata  out  32  extended load result, valid with cpu_rvalid
- cpu_rvalid  out  1  load result valid this cycle
- cpu_err  out  1  misaligned access, 1-cycle pulse
- dma_req  in  1  DMA request; held until granted
- dma_we  in  1  DMA store (always full word)
- dma_addr  in  32  byte address; bits [1:0] ignored
- dma_wdata  in  32  DMA store data
- dma_gnt  out  1  request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_be  out  4  byte enables
- ram_addr  out  ADDR_W  word index, equal to addr[13:2]
- ram_wdata  out  32  lane-aligned write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset: all outputs are 0; state is IDLE; wait counter is 0. Reset during CPU_RD or DMA_RD abandons the read; no rvalid is issued.
- States:
  - IDLE: arbitrates among requesters.
  - CPU_RD: one cycle; latches the returned word, raises cpu_rvalid, returns to IDLE.
  - DMA_RD: one cycle; raises dma_rvalid, returns to IDLE.
- Arbitration in IDLE: the CPU wins unless dma_req is set and the wait counter equals MAX_WAIT, in which case the DMA wins.
  - The wait counter increments each cycle dma_req is denied.
  - It clears on dma_gnt.
  - It saturates at MAX_WAIT.
- Stores complete in the issue cycle, with no stall.
  - ram_be: WORD = 1111; HALF = 0011 or 1100 by addr[1]; BYTE = one-hot of addr[1:0].
  - ram_wdata: the low half or low byte is replicated to all lanes.
- Loads: the issue cycle drives ram_en with ram_we=0 and asserts cpu_stall. In CPU_RD, cpu_stall=0 and cpu_rvalid=1. Load-to-use latency is therefore 1 extra cycle.
- Load result: lane selected by addr[1] (HALF) or addr[1:0] (BYTE), then zero- or sign-extended per cpu_loadop. cpu_width/addr/loadop are latched at issue.
- DMA owns the RAM (grant cycle, plus DMA_RD for reads): if cpu_req is set, cpu_stall=1 and nothing is issued for the CPU.
- A CPU request arriving during CPU_RD is the same held instruction. It is not re-issued; the CPU consumes the rvalid data.
- Misaligned access (WORD with addr[1:0]≠0, or HALF with addr[0]=1):
  - No RAM access and no stall.
  - cpu_err=1 for one cycle.
  - For a load, cpu_rdata=0 and cpu_rvalid=1 the next cycle.
- Addresses with a nonzero addr[31:14] are truncated; no error is raised.
- ram_en is never asserted for two requesters in the same cycle.

Optional Feature:
- DM_TRACE_EN defined: each committed CPU store prints time, byte address and the merged word. The merged word is formed from a shadow read-modify-write using ram_rdata captured on the previous read of the same word, else the lane data alone.
- DM_TRACE_EN undefined: no $display and no shadow logic; port list unchanged.

Decomposition:
- Shared package (macro header): width codes WORD/HALF/BYTE, state encodings IDLE/CPU_RD/DMA_RD, and MAX_WAIT default.
- One natural sub-module, dm_lane_unit: purely combinational. Computes be/wdata from width+addr and the extract/extend from width+addr+loadop. It is reused by any future cache.

Test Plan:
- CPU sb 0xA5 to addr 0x0000_0013 → ram_be=1000, ram_wdata=0xA5A5A5A5, ram_addr=4, no stall.
- After a word 0x8000_FF7F at addr 0x10, CPU lb addr 0x10 loadop=1 → stall 1 cycle, then cpu_rdata=0x0000_007F; lh addr 0x12 loadop=1 → 0xFFFF_8000; lhu → 0x0000_8000.
- CPU lw addr 0x0000_0006 → cpu_err pulse, no ram_en, cpu_rdata=0 with rvalid next cycle.
- dma_req held high while the CPU issues a store every cycle → dma_gnt on the 5th cycle (MAX_WAIT=4), cpu_stall=1 that cycle, and the counter returns to 0.
- DMA read of addr 0x40 while the CPU is idle → gnt, then dma_rvalid next cycle with the RAM word; concurrent cpu lw is stalled 2 cycles and completes afterwards.
- Reset asserted in the CPU_RD cycle → next cycle all outputs 0, state IDLE, no cpu_rvalid.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access width codes, FSM
// states and the DMA starvation limit. Optional build macro: DM_TRACE_EN.
package dm_arbiter_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } width_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CPU_RD = 2'b01,
        DMA_RD = 2'b10
    } state_e;

    // An access is misaligned when it straddles its natural boundary.
    // The unused code 2'b11 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
        case (width_e'(width))
            HALF:    return addr_lo[0];
            BYTE:    return 1'b0;
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_arbiter_lane.sv
// dm_lane_unit: byte-lane steering for stores and lane select/extend for
// loads. Purely combinational so a future cache can share it.
module dm_lane_unit
    import dm_arbiter_pkg::*;
(
    input  logic [1:0]        st_width,
    input  logic [1:0]        st_addr_lo,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        ld_width,
    input  logic [1:0]        ld_addr_lo,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_word,
    output logic [3:0]        be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [15:0] ld_half;
    logic [7:0]  ld_byte;

    // Store side: byte enables from width/offset, low data replicated to all lanes.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = st_wdata;
        case (width_e'(st_width))
            HALF: begin
                be_c    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{st_wdata[15:0]}};
            end
            BYTE: begin
                be_c    = 4'b0001 << st_addr_lo;
                wdata_c = {4{st_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane, then zero- or sign-extend it.
    always_comb begin
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        case (width_e'(ld_width))
            HALF:    rdata_c = {{16{ld_signed & ld_half[15]}}, ld_half};
            BYTE:    rdata_c = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            default: rdata_c = ld_word;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported data RAM between the M-stage
// load/store port and the DMA/debug port. Optional build macro DM_TRACE_EN
// adds a store trace built from a shadow read-modify-write.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        cpu_width,
    input  logic              cpu_loadop,
    output logic              cpu_stall,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_err,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [31:0]       dma_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_e           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       ld_width_q;
    logic [1:0]       ld_lo_q;
    logic             ld_signed_q;
    logic             err_rvalid_q;

    logic             wait_full;
    logic             arb_open;
    logic             cpu_misal;
    logic             dma_win;
    logic             cpu_win;
    logic             cpu_go;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;

    // Upper address bits are deliberately dropped (truncation, no error).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    dm_lane_unit u_lane (
        .st_width   (cpu_width),
        .st_addr_lo (cpu_addr[1:0]),
        .st_wdata   (cpu_wdata),
        .ld_width   (ld_width_q),
        .ld_addr_lo (ld_lo_q),
        .ld_signed  (ld_signed_q),
        .ld_word    (ram_rdata),
        .be_c       (lane_be),
        .wdata_c    (lane_wdata),
        .rdata_c    (lane_rdata)
    );

    // Arbitration: CPU first unless the DMA has waited MAX_WAIT cycles.
    always_comb begin
        wait_full = (wait_cnt == CNT_W'(MAX_WAIT));
        arb_open  = (state == IDLE) && !reset;
        cpu_misal = is_misaligned(cpu_width, cpu_addr[1:0]);
        dma_win   = arb_open && dma_req && (wait_full || !cpu_req);
        cpu_win   = arb_open && cpu_req && !dma_win;
        cpu_go    = cpu_win && !cpu_misal;
        dma_gnt   = dma_win;
        cpu_err   = cpu_win && cpu_misal;
        cpu_stall = cpu_req && !reset
                  && (dma_win || (state == DMA_RD) || (cpu_go && !cpu_we));
    end

    // RAM port mux: at most one requester drives the strobe per cycle.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = '0;
        ram_wdata = '0;
        if (dma_win) begin
            ram_en    = 1'b1;
            ram_we    = dma_we;
            ram_be    = dma_we ? 4'b1111 : 4'b0000;
            ram_addr  = dma_addr[ADDR_W+1:2];
            ram_wdata = dma_we ? dma_wdata : '0;
        end else if (cpu_go) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_be    = cpu_we ? lane_be : 4'b0000;
            ram_addr  = cpu_addr[ADDR_W+1:2];
            ram_wdata = cpu_we ? lane_wdata : '0;
        end
    end

    // Read-return outputs come straight from the read states.
    always_comb begin
        cpu_rvalid = (state == CPU_RD) || err_rvalid_q;
        cpu_rdata  = (state == CPU_RD) ? lane_rdata : '0;
        dma_rvalid = (state == DMA_RD);
        dma_rdata  = (state == DMA_RD) ? ram_rdata : '0;
    end

    // State, starvation counter and latched load attributes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ld_width_q   <= 2'b00;
            ld_lo_q      <= 2'b00;
            ld_signed_q  <= 1'b0;
            err_rvalid_q <= 1'b0;
        end else begin
            err_rvalid_q <= cpu_err && !cpu_we;

            if (cpu_go && !cpu_we) begin
                state <= CPU_RD;
            end else if (dma_win && !dma_we) begin
                state <= DMA_RD;
            end else begin
                state <= IDLE;
            end

            if (cpu_go && !cpu_we) begin
                ld_width_q  <= cpu_width;
                ld_lo_q     <= cpu_addr[1:0];
                ld_signed_q <= cpu_loadop;
            end

            if (dma_gnt) begin
                wait_cnt <= '0;
            end else if (dma_req && !wait_full) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DM_TRACE_EN
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] shadow_addr;
    logic [31:0]       shadow_data;
    logic              shadow_vld;
    logic [31:0]       merge_base;
    logic [31:0]       merged_c;

    // Merge the store lanes over the last word read from the same address.
    always_comb begin
        merge_base = (shadow_vld && (shadow_addr == ram_addr)) ? shadow_data : '0;
        for (int b = 0; b < 4; b++) begin
            merged_c[8*b +: 8] = ram_be[b] ? ram_wdata[8*b +: 8] : merge_base[8*b +: 8];
        end
    end

    // Shadow copy of the last read word, kept coherent with later writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_q   <= '0;
            shadow_addr <= '0;
            shadow_data <= '0;
            shadow_vld  <= 1'b0;
        end else begin
            if (ram_en && !ram_we) begin
                rd_addr_q <= ram_addr;
            end
            if (state != IDLE) begin
                shadow_addr <= rd_addr_q;
                shadow_data <= ram_rdata;
                shadow_vld  <= 1'b1;
            end else if (ram_en && ram_we && shadow_vld && (ram_addr == shadow_addr)) begin
                shadow_data <= merged_c;
            end
            if (cpu_go && cpu_we) begin
                $display("%0t dm_arbiter store addr=%08h data=%08h",
                         $time, cpu_addr, merged_c);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized
// load/store run checked against a byte-addressed memory model.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_loadop;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_width;
    logic        cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram_mem [0:4095];
    logic [7:0]  mdl     [0:16383];

    always #5 clk = ~clk;

    dm_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_width  (cpu_width),
        .cpu_loadop (cpu_loadop),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_err    (cpu_err),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_be     (ram_be),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM array: 1-cycle synchronous read, byte-enabled synchronous write.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input int w);
        return (w == 0) ? 4 : (w == 1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input int w, input logic sgn);
        int n;
        logic [31:0] v;
        n = nbytes(w);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mdl[int'(a[13:0]) + k]) << (8 * k));
        if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input int w, input logic [31:0] d);
        for (int k = 0; k < nbytes(w); k++) mdl[int'(a[13:0]) + k] = d[8*k +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] w, input logic op);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_width = w; cpu_loadop = op;
    endtask

    task automatic all_idle();
        cpu_drive(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [155:0] outs;
        reset = 1'b1;
        all_idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        outs = {cpu_stall, cpu_rdata, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_rdata,
                ram_en, ram_we, ram_be, ram_addr, ram_wdata, 20'd0};
        checks++;
        if (outs !== 156'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick();
    endtask

    task automatic test_store_byte();
        cpu_drive(1'b1, 1'b1, 32'h0000_0013, 32'h0000_00A5, 2'b10, 1'b0);
        #1;
        checks++;
        if (ram_be !== 4'b1000 || ram_wdata !== 32'hA5A5_A5A5 || ram_addr !== 12'd4 ||
            cpu_stall !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1) begin
            failures++;
            $display("FAIL store_byte: be=%b wdata=%h addr=%0d stall=%b en=%b we=%b expected be=1000 wdata=a5a5a5a5 addr=4 stall=0 en=1 we=1",
                     ram_be, ram_wdata, ram_addr, cpu_stall, ram_en, ram_we);
        end
        mdl_store(32'h13, 2, 32'hA5);
        tick();
        all_idle();
        tick();
    endtask

    task automatic test_load_ext();
        logic [31:0] la [3];
        logic [1:0]  lw [3];
        logic        lo [3];
        logic [31:0] le [3];
        la = '{32'h10, 32'h12, 32'h12};
        lw = '{2'b10, 2'b01, 2'b01};
        lo = '{1'b1, 1'b1, 1'b0};
        le = '{32'h0000_007F, 32'hFFFF_8000, 32'h0000_8000};
        cpu_drive(1'b1, 1'b1, 32'h10, 32'h8000_FF7F, 2'b00, 1'b0);
        #1;
        checks++;
        if (ram_be !== 4'b1111 || ram_wdata !== 32'h8000_FF7F || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL store_word: be=%b wdata=%h stall=%b expected be=1111 wdata=8000ff7f stall=0",
                     ram_be, ram_wdata, cpu_stall);
        end
        mdl_store(32'h10, 0, 32'h8000_FF7F);
        tick();
        for (int i = 0; i < 3; i++) begin
            cpu_drive(1'b1, 1'b0, la[i], 32'd0, lw[i], lo[i]);
            #1;
            checks++;
            if (cpu_stall !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'd4) begin
                failures++;
                $display("FAIL load_issue_%0d: stall=%b en=%b we=%b addr=%0d expected stall=1 en=1 we=0 addr=4",
                         i, cpu_stall, ram_en, ram_we, ram_addr);
            end
            tick();
            #1;
            checks++;
            if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0 || ram_en !== 1'b0 || cpu_rdata !== le[i]) begin
                failures++;
                $display("FAIL load_result_%0d: rvalid=%b stall=%b en=%b rdata=%h expected rvalid=1 stall=0 en=0 rdata=%h",
                         i, cpu_rvalid, cpu_stall, ram_en, cpu_rdata, le[i]);
            end
            tick();
        end
        all_idle();
        tick();
    endtask

    task automatic test_misaligned();
        cpu_drive(1'b1, 1'b0, 32'h0000_0006, 32'd0, 2'b00, 1'b0);
        #1;
        checks++;
        if (cpu_err !== 1'b1 || ram_en !== 1'b0 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_lw: err=%b en=%b stall=%b expected err=1 en=0 stall=0",
                     cpu_err, ram_en, cpu_stall);
        end
        tick();
        all_idle();
        #1;
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'd0 || cpu_err !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_lw_rvalid: rvalid=%b rdata=%h err=%b expected rvalid=1 rdata=0 err=0",
                     cpu_rvalid, cpu_rdata, cpu_err);
        end
        tick();
        cpu_drive(1'b1, 1'b1, 32'h0000_0005, 32'h1234, 2'b01, 1'b0);
        #1;
        checks++;
        if (cpu_err !== 1'b1 || ram_en !== 1'b0 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_sh: err=%b en=%b stall=%b expected err=1 en=0 stall=0",
                     cpu_err, ram_en, cpu_stall);
        end
        tick();
        all_idle();
        #1;
        checks++;
        if (cpu_rvalid !== 1'b0 || cpu_err !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_sh_after: rvalid=%b err=%b expected rvalid=0 err=0", cpu_rvalid, cpu_err);
        end
        tick();
    endtask

    task automatic test_dma_starve();
        int          idx;
        int          cyc;
        logic        got;
        logic [31:0] sa, sd;
        idx = 0;
        for (int run = 0; run < 2; run++) begin
            dma_req   = 1'b1;
            dma_we    = 1'b1;
            dma_addr  = 32'h100 + 32'(4 * run);
            dma_wdata = $urandom;
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 12) begin
                sa = 32'h200 + 32'(4 * idx);
                sd = 32'(idx + 1) * 32'h0101_0101;
                cpu_drive(1'b1, 1'b1, sa, sd, 2'b00, 1'b0);
                #1;
                cyc++;
                if (dma_gnt === 1'b1) begin
                    got = 1'b1;
                    checks++;
                    if (cpu_stall !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b1 ||
                        ram_addr !== dma_addr[13:2] || ram_wdata !== dma_wdata) begin
                        failures++;
                        $display("FAIL dma_grant_cycle: stall=%b en=%b we=%b addr=%0d wdata=%h expected stall=1 en=1 we=1 addr=%0d wdata=%h",
                                 cpu_stall, ram_en, ram_we, ram_addr, ram_wdata, dma_addr[13:2], dma_wdata);
                    end
                    mdl_store(dma_addr, 0, dma_wdata);
                end else begin
                    checks++;
                    if (cpu_stall !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== sa[13:2]) begin
                        failures++;
                        $display("FAIL dma_starve_cpu_store: stall=%b en=%b we=%b addr=%0d expected stall=0 en=1 we=1 addr=%0d",
                                 cpu_stall, ram_en, ram_we, ram_addr, sa[13:2]);
                    end
                    mdl_store(sa, 0, sd);
                    idx++;
                end
                tick();
            end
            dma_req = 1'b0;
            checks++;
            if (cyc !== 5) begin
                failures++;
                $display("FAIL dma_starve_latency_run%0d: got %0d cycles expected 5", run, cyc);
            end
        end
        all_idle();
        tick();
    endtask

    task automatic test_dma_read();
        logic [31:0] w;
        w = $urandom;
        cpu_drive(1'b1, 1'b1, 32'h40, w, 2'b00, 1'b0);
        mdl_store(32'h40, 0, w);
        tick();
        all_idle();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
        #1;
        checks++;
        if (dma_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'h10) begin
            failures++;
            $display("FAIL dma_read_grant: gnt=%b en=%b we=%b addr=%0d expected gnt=1 en=1 we=0 addr=16",
                     dma_gnt, ram_en, ram_we, ram_addr);
        end
        tick();
        dma_req = 1'b0;
        cpu_drive(1'b1, 1'b0, 32'h40, 32'd0, 2'b00, 1'b0);
        #1;
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== w || cpu_stall !== 1'b1 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL dma_read_data: rvalid=%b rdata=%h stall=%b en=%b expected rvalid=1 rdata=%h stall=1 en=0",
                     dma_rvalid, dma_rdata, cpu_stall, ram_en, w);
        end
        tick();
        #1;
        checks++;
        if (cpu_stall !== 1'b1 || ram_en !== 1'b1 || dma_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL dma_then_cpu_issue: stall=%b en=%b dma_rvalid=%b expected stall=1 en=1 dma_rvalid=0",
                     cpu_stall, ram_en, dma_rvalid);
        end
        tick();
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== w) begin
            failures++;
            $display("FAIL dma_then_cpu_result: stall=%b rvalid=%b rdata=%h expected stall=0 rvalid=1 rdata=%h",
                     cpu_stall, cpu_rvalid, cpu_rdata, w);
        end
        tick();
        all_idle();
        tick();
    endtask

    task automatic test_reset_in_rd();
        logic [155:0] outs;
        cpu_drive(1'b1, 1'b0, 32'h40, 32'd0, 2'b00, 1'b0);
        tick();
        all_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        outs = {cpu_stall, cpu_rdata, cpu_rvalid, cpu_err, dma_gnt, dma_rvalid, dma_rdata,
                ram_en, ram_we, ram_be, ram_addr, ram_wdata, 20'd0};
        checks++;
        if (outs !== 156'd0) begin
            failures++;
            $display("FAIL reset_in_cpu_rd: got %h expected 0 (rvalid=%b)", outs, cpu_rvalid);
        end
        tick();
        cpu_drive(1'b1, 1'b1, 32'h80, 32'hCAFE_F00D, 2'b00, 1'b0);
        mdl_store(32'h80, 0, 32'hCAFE_F00D);
        #1;
        checks++;
        if (ram_en !== 1'b1 || cpu_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_back_to_idle: en=%b stall=%b expected en=1 stall=0", ram_en, cpu_stall);
        end
        tick();
        all_idle();
        tick();
    endtask

    task automatic test_random();
        int          w;
        logic [31:0] a, full, d, exp;
        logic        we, op, mis;
        for (int i = 0; i < 300; i++) begin
            w  = $urandom_range(0, 2);
            a  = 32'($urandom_range(0, 12287));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(w) - 1);
            full = {18'($urandom), a[13:0]};
            we = 1'($urandom_range(0, 1));
            op = 1'($urandom_range(0, 1));
            d  = $urandom;
            mis = (w == 0 && a[1:0] != 2'b00) || (w == 1 && a[0]);
            cpu_drive(1'b1, we, full, d, 2'(w), op);
            #1;
            if (mis) begin
                checks++;
                if (cpu_err !== 1'b1 || ram_en !== 1'b0 || cpu_stall !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_misaligned_%0d: err=%b en=%b stall=%b expected err=1 en=0 stall=0",
                             i, cpu_err, ram_en, cpu_stall);
                end
                tick();
                cpu_req = 1'b0;
                #1;
                checks++;
                if (cpu_rvalid !== !we || cpu_rdata !== 32'd0) begin
                    failures++;
                    $display("FAIL rand_misaligned_rv_%0d: rvalid=%b rdata=%h expected rvalid=%b rdata=0",
                             i, cpu_rvalid, cpu_rdata, !we);
                end
            end else if (we) begin
                checks++;
                if (cpu_stall !== 1'b0 || cpu_err !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1 ||
                    ram_addr !== a[13:2]) begin
                    failures++;
                    $display("FAIL rand_store_%0d: stall=%b err=%b en=%b we=%b addr=%0d expected stall=0 err=0 en=1 we=1 addr=%0d",
                             i, cpu_stall, cpu_err, ram_en, ram_we, ram_addr, a[13:2]);
                end
                mdl_store(a, w, d);
            end else begin
                exp = mdl_load(a, w, op);
                checks++;
                if (cpu_stall !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0 || cpu_err !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_load_issue_%0d: stall=%b en=%b we=%b err=%b expected stall=1 en=1 we=0 err=0",
                             i, cpu_stall, ram_en, ram_we, cpu_err);
                end
                tick();
                #1;
                checks++;
                if (cpu_rvalid !== 1'b1 || cpu_stall !== 1'b0 || ram_en !== 1'b0 || cpu_rdata !== exp) begin
                    failures++;
                    $display("FAIL rand_load_%0d: addr=%h w=%0d op=%b rvalid=%b stall=%b en=%b rdata=%h expected rvalid=1 stall=0 en=0 rdata=%h",
                             i, a, w, op, cpu_rvalid, cpu_stall, ram_en, cpu_rdata, exp);
                end
            end
            tick();
            if ($urandom_range(0, 3) == 0) begin
                cpu_req = 1'b0;
                tick();
            end
        end
        all_idle();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = 32'd0;
        for (int i = 0; i < 16384; i++) mdl[i] = 8'd0;
        ram_rdata = 32'd0;
        reset = 1'b1;
        all_idle();
        repeat (3) tick();
        test_reset();
        test_store_byte();
        test_load_ext();
        test_misaligned();
        test_dma_starve();
        test_dma_read();
        test_reset_in_rd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
